// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: state codes,
// opcode/func constants, datapath select encodings and the ALU decode class.
package mips_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_EXEC_R = 4'd2;
    localparam state_t S_EXEC_I = 4'd3;
    localparam state_t S_ADDR   = 4'd4;
    localparam state_t S_MEM_RD = 4'd5;
    localparam state_t S_MEM_WB = 4'd6;
    localparam state_t S_MEM_WR = 4'd7;
    localparam state_t S_WB_R   = 4'd8;
    localparam state_t S_WB_I   = 4'd9;
    localparam state_t S_BRANCH = 4'd10;
    localparam state_t S_JUMP   = 4'd11;
    localparam state_t S_JAL    = 4'd12;
    localparam state_t S_JR     = 4'd13;
    localparam state_t S_HALT   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_REGA = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [2:0] {
        ALU_CLS_NONE = 3'd0,
        ALU_CLS_ADD  = 3'd1,
        ALU_CLS_SUB  = 3'd2,
        ALU_CLS_R    = 3'd3,
        ALU_CLS_I    = 3'd4
    } alu_cls_e;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       wd_inp;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface mips_mc_controller_if;
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic       MemToReg;
    logic       WDInp;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOperation;
    logic [1:0] PCSrc;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opc, func, zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               WDInp, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc,
               illegal_op, mem_timeout
    );

    modport slave (
        output opc, func, zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               WDInp, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc,
               illegal_op, mem_timeout
    );
endinterface

// File: rtl/mips_mc_alu_dec.sv
// ALU operation decode from the controller's state class plus opcode/func fields.
module mips_mc_alu_dec
    import mips_mc_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    output logic [2:0] alu_op
);

    // Map the requested ALU class onto a concrete operation.
    always_comb begin
        alu_op = ALU_AND;
        case (cls)
            ALU_CLS_ADD: alu_op = ALU_ADD;
            ALU_CLS_SUB: alu_op = ALU_SUB;
            ALU_CLS_R: begin
                case (func)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_AND;
                endcase
            end
            ALU_CLS_I: begin
                case (opc)
                    OP_ADDI: alu_op = ALU_ADD;
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with memory-ready wait, timeout and illegal-op faults.
// Optional feature: define MIPS_MC_BNE_EN to decode bne as a branch on ~zero.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input logic                  clk,
    input logic                  rst,
    mips_mc_controller_if.master bus
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state_r;
    state_t          dispatch_s;
    state_t          state_nxt_s;
    logic [TO_W-1:0] wait_cnt_r;
    logic            illegal_r;
    logic            timeout_r;
    logic            illegal_set_s;
    logic            wait_s;
    logic            timeout_hit_s;
    logic            br_cond_s;
    ctrl_t           ctrl_s;
    ctrl_t           ctrl_g_s;
    alu_cls_e        alu_cls_s;
    logic [2:0]      alu_op_s;

    assign wait_s        = is_mem_state(state_r) & ~bus.mem_ready;
    assign timeout_hit_s = (TIMEOUT != 32'sd0) && wait_s && (wait_cnt_r == TO_LIM);
    assign state_nxt_s   = timeout_hit_s ? S_HALT : dispatch_s;

`ifdef MIPS_MC_BNE_EN
    assign br_cond_s = (bus.opc == OP_BNE) ? ~bus.zero : bus.zero;
`else
    assign br_cond_s = bus.zero;
`endif

    // Next-state sequencing and opcode dispatch.
    always_comb begin
        dispatch_s    = S_HALT;
        illegal_set_s = 1'b0;
        case (state_r)
            S_FETCH:  dispatch_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opc)
                    OP_RTYPE: begin
                        case (bus.func)
                            F_ADD, F_SUB, F_AND, F_OR, F_SLT: dispatch_s = S_EXEC_R;
                            F_JR:    dispatch_s = S_JR;
                            default: illegal_set_s = 1'b1;
                        endcase
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: dispatch_s = S_EXEC_I;
                    OP_LW, OP_SW: dispatch_s = S_ADDR;
                    OP_BEQ:       dispatch_s = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       dispatch_s = S_BRANCH;
`endif
                    OP_J:         dispatch_s = S_JUMP;
                    OP_JAL:       dispatch_s = S_JAL;
                    default:      illegal_set_s = 1'b1;
                endcase
            end
            S_EXEC_R: dispatch_s = S_WB_R;
            S_EXEC_I: dispatch_s = S_WB_I;
            S_ADDR:   dispatch_s = (bus.opc == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: dispatch_s = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: dispatch_s = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_JAL, S_JR: dispatch_s = S_FETCH;
            S_HALT:   dispatch_s = S_HALT;
            default:  dispatch_s = S_HALT;
        endcase
    end

    // Moore control decode per state; FETCH and BRANCH fold in their live inputs.
    always_comb begin
        ctrl_s    = '0;
        alu_cls_s = ALU_CLS_NONE;
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.pc_src    = PCSRC_ALU;
                ctrl_s.ir_write  = bus.mem_ready;
                ctrl_s.pc_write  = bus.mem_ready;
                alu_cls_s        = ALU_CLS_ADD;
            end
            S_DECODE: begin
                ctrl_s.alu_src_b = SRCB_IMM_SH;
                alu_cls_s        = ALU_CLS_ADD;
            end
            S_EXEC_R: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_B;
                alu_cls_s        = ALU_CLS_R;
            end
            S_EXEC_I: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                alu_cls_s        = ALU_CLS_I;
            end
            S_ADDR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                alu_cls_s        = ALU_CLS_ADD;
            end
            S_MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_s.reg_dst    = REGDST_RT;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_write  = 1'b1;
            end
            S_WB_R: begin
                ctrl_s.reg_dst   = REGDST_RD;
                ctrl_s.reg_write = 1'b1;
            end
            S_WB_I: begin
                ctrl_s.reg_dst   = REGDST_RT;
                ctrl_s.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_B;
                ctrl_s.pc_src    = PCSRC_OUT;
                ctrl_s.pc_write  = br_cond_s;
                alu_cls_s        = ALU_CLS_SUB;
            end
            S_JUMP: begin
                ctrl_s.pc_src   = PCSRC_JMP;
                ctrl_s.pc_write = 1'b1;
            end
            S_JAL: begin
                ctrl_s.pc_src    = PCSRC_JMP;
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.reg_dst   = REGDST_RA;
                ctrl_s.wd_inp    = 1'b1;
                ctrl_s.reg_write = 1'b1;
            end
            S_JR: begin
                ctrl_s.pc_src   = PCSRC_REGA;
                ctrl_s.pc_write = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    mips_mc_alu_dec u_alu_dec (
        .cls    (alu_cls_s),
        .opc    (bus.opc),
        .func   (bus.func),
        .alu_op (alu_op_s)
    );

    // State register, memory wait counter and sticky fault flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= '0;
            illegal_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= (wait_s && !timeout_hit_s) ? (wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1}) : '0;
            illegal_r  <= illegal_r | illegal_set_s;
            timeout_r  <= timeout_r | timeout_hit_s;
        end
    end

    // Reset gates the decode directly so no strobe survives an asynchronous abort.
    assign ctrl_g_s         = rst ? ctrl_s : '0;
    assign bus.PCWrite      = ctrl_g_s.pc_write;
    assign bus.IorD         = ctrl_g_s.iord;
    assign bus.MemRead      = ctrl_g_s.mem_read;
    assign bus.MemWrite     = ctrl_g_s.mem_write;
    assign bus.IRWrite      = ctrl_g_s.ir_write;
    assign bus.RegDst       = ctrl_g_s.reg_dst;
    assign bus.MemToReg     = ctrl_g_s.mem_to_reg;
    assign bus.WDInp        = ctrl_g_s.wd_inp;
    assign bus.RegWrite     = ctrl_g_s.reg_write;
    assign bus.ALUSrcA      = ctrl_g_s.alu_src_a;
    assign bus.ALUSrcB      = ctrl_g_s.alu_src_b;
    assign bus.PCSrc        = ctrl_g_s.pc_src;
    assign bus.ALUOperation = rst ? alu_op_s : 3'b000;
    assign bus.illegal_op   = illegal_r;
    assign bus.mem_timeout  = timeout_r;

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multi-cycle control unit for the next-generation MIPS core, replacing the single-cycle controller/datapath pairing under the top-level `MIPS` wrapper. It is a registered FSM that sequences fetch, decode, execute, memory and write-back over several cycles. It waits on a memory-ready handshake with a parametrised timeout and flags illegal opcodes. Outputs drive the shared-ALU, single-memory multi-cycle datapath.

## Interface
- `TIMEOUT`, default 15: maximum memory wait cycles before fault; 0 disables the timeout.
- `TO_W`, default 4: wait-counter width; must satisfy 2^TO_W > TIMEOUT.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opc`  in  6  instruction opcode, taken from the instruction register.
- `func`  in  6  R-type function field.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  PC load, already OR-ed with the branch condition.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead` / `MemWrite`  out  1  memory strobes.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- `MemToReg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `WDInp`  out  1  1 = write PC into the register file (jal).
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A operand: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `ALUOperation`  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- `PCSrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `illegal_op`  out  1  sticky; set on an undecodable instruction.
- `mem_timeout`  out  1  sticky; set when the wait limit is exceeded.

## Operation
- State register is reset asynchronously on `rst`=0 to FETCH. While in reset, all outputs are 0 and the wait counter is 0.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, JAL, JR, HALT.
- FETCH:
  - `MemRead`=1, `IorD`=0, ALU computes PC+4.
  - On `mem_ready`: `IRWrite`=1 and `PCWrite`=1 in the same cycle, then go to DECODE.
- DECODE: ALU computes PC+(imm<<2) into ALUOut. Dispatch by opcode:
  - R-type (000000), func add/sub/and/or/slt → EXEC_R; jr (func 001000) → JR.
  - addi / slti / andi / ori → EXEC_I.
  - lw / sw → ADDR.
  - beq → BRANCH.
  - j → JUMP.
  - jal → JAL.
  - Anything else → HALT with `illegal_op` set.
- EXEC_R → WB_R (`RegDst`=01, `RegWrite`=1).
- EXEC_I → WB_I (`RegDst`=00, `RegWrite`=1).
- ADDR → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD and MEM_WR hold their strobe (`IorD`=1) until `mem_ready`.
- MEM_RD → MEM_WB (`MemToReg`=1, `RegWrite`=1).
- BRANCH: `ALUOperation`=sub, `PCSrc`=01, `PCWrite`=`zero`.
- JUMP: `PCSrc`=10.
- JAL: `PCSrc`=10, `RegDst`=10, `WDInp`=1, `RegWrite`=1.
- JR: `PCSrc`=11.
- After every terminal state, return to FETCH.
- Wait counter:
  - Counts cycles in which a memory strobe is high and `mem_ready`=0.
  - Clears on `mem_ready` or on leaving the state.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`: set `mem_timeout`, go to HALT.
- HALT: all control outputs 0; the state is left only by reset.

## Timing
- The state register is the only sequential element besides the counter and sticky flags.
- Outputs are Moore decodes of the state, except: `PCWrite` in BRANCH depends combinationally on `zero`, and `IRWrite`/`PCWrite` in FETCH depend combinationally on `mem_ready`.
- CPI at zero wait states:
  - R-type / I-ALU / sw: 4.
  - lw: 5.
  - beq / j / jal / jr: 3.
- Each wait cycle adds 1.
- `mem_ready` high outside a memory state is ignored.
- Reset asserted mid-instruction aborts it at once; no write strobe may remain high after reset assertion.
- With `TIMEOUT`=N, exactly N consecutive not-ready cycles still succeed if `mem_ready` arrives on cycle N+1. After N+1 not-ready cycles, HALT is entered on the following edge.

## Configuration
- `MIPS_MC_BNE_EN` defined: bne (000101) is decoded → BRANCH, with `PCWrite`=~`zero`.
- Undefined: bne is illegal → HALT, `illegal_op`=1.

## Structure
- `mips_mc_pkg` holds:
  - state enum;
  - opcode and func constants;
  - `ALUOperation`, `PCSrc`, `RegDst` and `ALUSrcB` encodings.
- One sub-module, `mips_mc_alu_dec`: combinational mapping of (state class, opc, func) → `ALUOperation`.

## Test plan
- add $3,$1,$2 with `mem_ready` tied 1 → FETCH, DECODE, EXEC_R, WB_R; `RegDst`=01, `RegWrite`=1 for exactly 1 cycle; 4 cycles total.
- lw with 2 wait cycles in both FETCH and MEM_RD → 9 cycles total; `IRWrite` pulses only on the ready cycle.
- beq with `zero`=1, then with `zero`=0 → `PCWrite`=1 in BRANCH for the first, 0 for the second; `PCSrc`=01 for both.
- jal → JAL cycle shows `RegDst`=10, `WDInp`=1, `PCSrc`=10, `PCWrite`=1.
- `TIMEOUT`=3, `mem_ready` held 0 in FETCH → `mem_timeout`=1 after the 4th wait cycle; outputs stay 0 until `rst` pulses low.
- opc 000101 → with `MIPS_MC_BNE_EN` defined, branches when `zero`=0; without it, `illegal_op`=1 and the FSM is in HALT.
